// File: rtl/dmr_pkg.sv
// Shared types and constants for the DMR instruction retry slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmr_pkg;

   // Retry FSM state encoding
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REPLAY = 2'd1,
      FATAL  = 2'd2
   } dmr_retry_state_e;

   localparam int unsigned DmrDefaultMaxRetries = 3;
   localparam int unsigned DmrErrCntWidth       = 16;

endpackage

// File: rtl/dmr_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
// Latency: count visible one cycle after the enabling cycle.
// Backpressure: none; holds at all-ones once saturated.
module dmr_sat_counter #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [Width-1:0] cnt_o
);

   logic [Width-1:0] r_cnt;

   // Count up on enable, stop at all-ones, clear has priority
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (clr_i) begin
         r_cnt <= '0;
      end else if (en_i && (r_cnt != {Width{1'b1}})) begin
         r_cnt <= r_cnt + Width'(1);
      end
   end

   assign cnt_o = r_cnt;

endmodule

// File: rtl/dmr_instr_retry.sv
// Per-lane fetch retry stage: replays the last agreed fetch on a lockstep mismatch, goes fatal after MaxRetries.
// Latency: zero-latency pass-through in IDLE; replayed request presented the cycle after an error.
// Backpressure: core stalled (core_ready_o=0) during replay/fatal; error_i suppresses acknowledge. Optional stats: DMR_INSTR_RETRY_STATS_EN.
module dmr_instr_retry
   import dmr_pkg::*;
#(
   parameter type         addr_t     = logic,
   parameter type         data_t     = logic,
   parameter int unsigned MaxRetries = DmrDefaultMaxRetries,
   localparam int unsigned CntWidth  = $clog2(MaxRetries + 1)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      core_valid_i,
   output logic                      core_ready_o,
   input  addr_t                     core_addr_i,
   output data_t                     core_data_o,
   output logic                      valid_o,
   input  logic                      ready_i,
   output addr_t                     addr_o,
   input  data_t                     data_i,
   input  logic                      error_i,
   output logic [CntWidth-1:0]       retry_cnt_o,
   output logic                      fatal_o,
   output logic [DmrErrCntWidth-1:0] err_total_o
);

   dmr_retry_state_e    r_state;
   addr_t               r_addr_q;
   logic                r_valid_q;
   logic                r_fatal;

   logic                w_err_cyc;
   logic                w_retry_clr;
   logic [CntWidth-1:0] w_retry_cnt;
   logic [CntWidth-1:0] w_retry_inc;

   // Errors only count while the lane is still alive
   assign w_err_cyc   = error_i & (r_state != FATAL);
   // Leaving REPLAY: lanes agreed and the replayed request completed (or there was nothing to replay)
   assign w_retry_clr = (r_state == REPLAY) & ~error_i & (ready_i | ~r_valid_q);
   assign w_retry_inc = w_retry_cnt + CntWidth'(1);

   dmr_sat_counter #(
      .Width (CntWidth)
   ) u_retry_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (w_retry_clr),
      .en_i   (w_err_cyc),
      .cnt_o  (w_retry_cnt)
   );

   // Retry FSM: tracks last agreed request and escalates to sticky FATAL
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= IDLE;
         r_addr_q  <= '0;
         r_valid_q <= 1'b0;
         r_fatal   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (error_i) begin
                  // Counter goes 0 -> 1 on this same edge
                  if (MaxRetries == 1) begin
                     r_state <= FATAL;
                     r_fatal <= 1'b1;
                  end else begin
                     r_state <= REPLAY;
                  end
               end else begin
                  r_addr_q  <= core_addr_i;
                  r_valid_q <= core_valid_i;
               end
            end
            REPLAY: begin
               if (error_i) begin
                  if (w_retry_inc == CntWidth'(MaxRetries)) begin
                     r_state <= FATAL;
                     r_fatal <= 1'b1;
                  end
               end else if (ready_i || !r_valid_q) begin
                  r_state <= IDLE;
               end
            end
            FATAL: begin
               r_state <= FATAL;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign addr_o       = (r_state == IDLE) ? core_addr_i : r_addr_q;
   assign valid_o      = (r_state == IDLE)   ? core_valid_i :
                         (r_state == REPLAY) ? r_valid_q    : 1'b0;
   assign core_ready_o = (r_state == IDLE) & ready_i & ~error_i & core_valid_i;
   assign core_data_o  = data_i;
   assign fatal_o      = r_fatal;
   assign retry_cnt_o  = w_retry_cnt;

`ifdef DMR_INSTR_RETRY_STATS_EN
   dmr_sat_counter #(
      .Width (DmrErrCntWidth)
   ) u_err_total (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (1'b0),
      .en_i   (w_err_cyc),
      .cnt_o  (err_total_o)
   );
`else
   assign err_total_o = '0;
`endif

endmodule

// File: tb/tb_dmr_instr_retry.sv
// Self-checking bench for dmr_instr_retry (MaxRetries = 3, 32-bit address/data).
// Behavioural model of lane health plus directed literal checks.
// Stimulus driven 1 time unit after posedge; outputs sampled on negedge.
module tb_dmr_instr_retry;

   localparam int unsigned MAXR = 3;

   logic        clk;
   logic        rst_n;
   logic        core_valid;
   logic        core_ready;
   logic [31:0] core_addr;
   logic [31:0] core_data;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] addr_o;
   logic [31:0] data_i;
   logic        error_i;
   logic [1:0]  retry_cnt;
   logic        fatal;
   logic [15:0] err_total;

   int n_chk  = 0;
   int n_fail = 0;

   dmr_instr_retry #(
      .addr_t     (logic [31:0]),
      .data_t     (logic [31:0]),
      .MaxRetries (MAXR)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .core_valid_i (core_valid),
      .core_ready_o (core_ready),
      .core_addr_i  (core_addr),
      .core_data_o  (core_data),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .addr_o       (addr_o),
      .data_i       (data_i),
      .error_i      (error_i),
      .retry_cnt_o  (retry_cnt),
      .fatal_o      (fatal),
      .err_total_o  (err_total)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: lane is either passing through, replaying a remembered request, or dead.
   bit          m_dead;
   bit          m_replay;
   int          m_fails;
   logic [31:0] m_addr;
   bit          m_vld;
   int          m_err_total;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_dead = 0; m_replay = 0; m_fails = 0;
         m_addr = 0; m_vld = 0; m_err_total = 0;
      end else if (!m_dead) begin
         if (error_i) begin
            if (m_err_total < 65535) m_err_total++;
            m_fails++;
            if (m_fails >= MAXR) m_dead = 1;
            else m_replay = 1;
         end else if (m_replay) begin
            if (ready_i || !m_vld) begin
               m_replay = 0;
               m_fails  = 0;
            end
         end else begin
            m_addr = core_addr;
            m_vld  = core_valid;
         end
      end
   end

   function automatic int exp_err_total();
`ifdef DMR_INSTR_RETRY_STATS_EN
      return m_err_total;
`else
      return 0;
`endif
   endfunction

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_core_data", core_data, data_i);
         chk("m_fatal", {31'd0, fatal}, {31'd0, m_dead});
         chk("m_retry_cnt", {30'd0, retry_cnt}, m_fails);
         chk("m_err_total", {16'd0, err_total}, exp_err_total());
         if (m_dead) begin
            chk("m_valid_o", {31'd0, valid_o}, 32'd0);
            chk("m_core_ready", {31'd0, core_ready}, 32'd0);
         end else if (m_replay) begin
            chk("m_valid_o", {31'd0, valid_o}, {31'd0, m_vld});
            chk("m_addr_o", addr_o, m_addr);
            chk("m_core_ready", {31'd0, core_ready}, 32'd0);
         end else begin
            chk("m_valid_o", {31'd0, valid_o}, {31'd0, core_valid});
            chk("m_addr_o", addr_o, core_addr);
            chk("m_core_ready", {31'd0, core_ready},
                {31'd0, ready_i & ~error_i & core_valid});
         end
      end
   end

   // Apply one cycle of inputs, return at the sampling edge of that cycle
   task automatic drive(input logic v, input logic [31:0] a, input logic rdy, input logic err);
      @(posedge clk);
      #1;
      core_valid = v;
      core_addr  = a;
      ready_i    = rdy;
      error_i    = err;
      data_i     = a ^ 32'hA5A5_0000;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; core_valid = 0; core_addr = 0; ready_i = 0; error_i = 0; data_i = 0;
      #3;
      chk("rst_fatal", {31'd0, fatal}, 32'd0);
      chk("rst_cnt", {30'd0, retry_cnt}, 32'd0);
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_err_total", {16'd0, err_total}, 32'd0);
      #4 rst_n = 1'b1;

      // Plain pass-through
      drive(1, 32'h100, 1, 0);
      chk("pt_ready0", {31'd0, core_ready}, 32'd1);
      chk("pt_addr0", addr_o, 32'h100);
      chk("pt_data0", core_data, 32'hA5A5_0100);
      drive(1, 32'h104, 1, 0);
      chk("pt_ready1", {31'd0, core_ready}, 32'd1);
      chk("pt_addr1", addr_o, 32'h104);
      chk("pt_cnt", {30'd0, retry_cnt}, 32'd0);
      drive(0, 32'h108, 1, 0);
      chk("pt_novalid", {31'd0, core_ready}, 32'd0);

      // Single error with simultaneous ready, then stalled replay
      drive(1, 32'h200, 1, 0);
      drive(1, 32'h204, 1, 1);
      chk("err_rdy_noack", {31'd0, core_ready}, 32'd0);
      drive(1, 32'h204, 0, 0);
      chk("rp_addr", addr_o, 32'h200);
      chk("rp_valid", {31'd0, valid_o}, 32'd1);
      chk("rp_ready", {31'd0, core_ready}, 32'd0);
      chk("rp_cnt1", {30'd0, retry_cnt}, 32'd1);
      drive(1, 32'h204, 1, 0);
      chk("rp_hold_addr", addr_o, 32'h200);
      drive(1, 32'h204, 1, 0);
      chk("rec_addr", addr_o, 32'h204);
      chk("rec_ready", {31'd0, core_ready}, 32'd1);
      chk("rec_cnt0", {30'd0, retry_cnt}, 32'd0);

      // Two more two-error episodes, recovering each time
      drive(1, 32'h208, 1, 1);
      drive(1, 32'h208, 1, 1);
      chk("epb_cnt1", {30'd0, retry_cnt}, 32'd1);
      drive(1, 32'h208, 1, 0);
      chk("epb_cnt2", {30'd0, retry_cnt}, 32'd2);
      drive(1, 32'h208, 1, 0);
      drive(1, 32'h20C, 1, 1);
      drive(1, 32'h20C, 1, 1);
      drive(1, 32'h20C, 1, 0);
      drive(1, 32'h20C, 1, 0);
      chk("epc_recovered", {31'd0, core_ready}, 32'd1);
`ifdef DMR_INSTR_RETRY_STATS_EN
      chk("err_total5", {16'd0, err_total}, 32'd5);
`else
      chk("err_total0", {16'd0, err_total}, 32'd0);
`endif

      // Reset while replaying with count 2
      drive(1, 32'h300, 1, 0);
      drive(1, 32'h304, 1, 1);
      drive(1, 32'h304, 1, 1);
      drive(1, 32'h304, 0, 0);
      chk("pre_rst_cnt2", {30'd0, retry_cnt}, 32'd2);
      chk("pre_rst_addr", addr_o, 32'h300);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_cnt", {30'd0, retry_cnt}, 32'd0);
      chk("mid_rst_fatal", {31'd0, fatal}, 32'd0);
      chk("mid_rst_valid", {31'd0, valid_o}, 32'd1);
      chk("mid_rst_addr", addr_o, 32'h304);
      chk("mid_rst_err_total", {16'd0, err_total}, 32'd0);
      #1 rst_n = 1'b1;
      drive(1, 32'h304, 1, 0);
      chk("post_rst_ready", {31'd0, core_ready}, 32'd1);
      chk("post_rst_addr", addr_o, 32'h304);

      // Replay of an invalid agreed slot exits without waiting for ready
      drive(0, 32'h500, 0, 0);
      drive(1, 32'h504, 0, 1);
      drive(1, 32'h504, 0, 0);
      chk("rp_inv_valid", {31'd0, valid_o}, 32'd0);
      drive(1, 32'h504, 0, 0);
      chk("rp_inv_exit", addr_o, 32'h504);

      // Escalation to fatal
      drive(1, 32'h400, 1, 0);
      drive(1, 32'h404, 1, 1);
      drive(1, 32'h404, 1, 1);
      chk("ft_cnt1", {30'd0, retry_cnt}, 32'd1);
      drive(1, 32'h404, 1, 1);
      chk("ft_cnt2", {30'd0, retry_cnt}, 32'd2);
      chk("ft_not_yet", {31'd0, fatal}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'h404, 1, 0);
         chk("ft_fatal", {31'd0, fatal}, 32'd1);
         chk("ft_valid", {31'd0, valid_o}, 32'd0);
         chk("ft_ready", {31'd0, core_ready}, 32'd0);
         chk("ft_cnt3", {30'd0, retry_cnt}, 32'd3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
